decode_queue: RTL and testbench

//  Parametrised fetch-to-dispatch decode stage with buffering. It queues fetched
//  {inst, pc, predicted_taken} entries in a DEPTH-entry circular FIFO and decodes
//  the head entry into a registered output slot. The downstream side then issues
//  to the regfile, ROB, RS and LSqueue.
//  It adds valid/ready handshakes on both sides, flush on mispredict, unit

---
 rtl/decode_queue_if.sv | 42 ++++
 rtl/decode_queue.sv | 214 +++++++++++++++++++++
 tb/tb_decode_queue.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_queue_if.sv
// rtl/decode_queue_if.sv - fetch/dispatch handshake bundle for decode_queue
// Purpose: groups the fetch-side enqueue channel and the dispatch-side decoded slot.
// Ports (slave = queue view):
//   in_valid/in_ready/in_inst/in_pc/in_pred_taken  fetch entry handshake
//   in_flush                                       discard all queued state
//   out_valid/out_ready                            decoded slot handshake
//   out_unit/out_funct3/out_funct7b5/out_rs1/out_rs2/out_rd/out_imm/out_pc/out_pred_taken/out_inst
//                                                  decoded slot contents
interface decode_queue_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_inst;
  logic [XLEN-1:0] in_pc;
  logic            in_pred_taken;
  logic            in_flush;
  logic            out_valid;
  logic            out_ready;
  logic [1:0]      out_unit;
  logic [2:0]      out_funct3;
  logic            out_funct7b5;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [4:0]      out_rd;
  logic [XLEN-1:0] out_imm;
  logic [XLEN-1:0] out_pc;
  logic            out_pred_taken;
  logic [31:0]     out_inst;

  modport slave (
    input  in_valid, in_inst, in_pc, in_pred_taken, in_flush, out_ready,
    output in_ready, out_valid, out_unit, out_funct3, out_funct7b5,
           out_rs1, out_rs2, out_rd, out_imm, out_pc, out_pred_taken, out_inst
  );

  modport master (
    output in_valid, in_inst, in_pc, in_pred_taken, in_flush, out_ready,
    input  in_ready, out_valid, out_unit, out_funct3, out_funct7b5,
           out_rs1, out_rs2, out_rd, out_imm, out_pc, out_pred_taken, out_inst
  );
endinterface

// File: rtl/decode_queue.sv
// rtl/decode_queue.sv - buffered RV32I fetch-to-dispatch decode stage
// Purpose: DEPTH-entry circular FIFO of {inst, pc, pred_taken} feeding one
//   registered decoded output slot; unit classification and illegal detection.
// Ports:
//   clk  clock, all state on posedge
//   rst  synchronous active-high reset
//   q    decode_queue_if.slave: fetch handshake, flush, decoded slot handshake
module decode_queue #(
  parameter int DEPTH = 8,
  parameter int XLEN  = 32
) (
  input  logic          clk,
  input  logic          rst,
  decode_queue_if.slave q
);
  localparam int              PTR_W   = $clog2(DEPTH);
  localparam logic [PTR_W:0]  FULL    = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [PTR_W:0]  CNT_ONE = (PTR_W+1)'(1);

  localparam logic [1:0] UNIT_ALU     = 2'd0;
  localparam logic [1:0] UNIT_BRANCH  = 2'd1;
  localparam logic [1:0] UNIT_LSQ     = 2'd2;
  localparam logic [1:0] UNIT_ILLEGAL = 2'd3;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef struct packed {
    logic [31:0]     inst;
    logic [XLEN-1:0] pc;
    logic            pred_taken;
  } entry_t;

  typedef struct packed {
    logic [1:0]      unit;
    logic [2:0]      funct3;
    logic            funct7b5;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic            pred_taken;
    logic [31:0]     inst;
  } dec_t;

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             out_valid_q, out_valid_d;
  dec_t             dec_q, dec_d;

  entry_t           head;
  dec_t             head_dec;
  logic             push, pop;
  logic [XLEN-1:0]  imm_i, imm_s, imm_b, imm_u, imm_j;

  assign q.in_ready = (count_q != FULL);
  assign push       = q.in_valid && q.in_ready && !q.in_flush;
  // The slot refills from the head whenever it is empty or being consumed.
  assign pop        = (count_q != '0) && (!out_valid_q || q.out_ready) && !q.in_flush;
  assign head       = mem_q[rd_ptr_q];

  assign imm_i = XLEN'($signed(head.inst[31:20]));
  assign imm_s = XLEN'($signed({head.inst[31:25], head.inst[11:7]}));
  assign imm_b = XLEN'($signed({head.inst[31], head.inst[7], head.inst[30:25], head.inst[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({head.inst[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({head.inst[31], head.inst[19:12], head.inst[20], head.inst[30:21], 1'b0}));

  always_comb begin
    head_dec            = '0;
    head_dec.unit       = UNIT_ILLEGAL;
    head_dec.pc         = head.pc;
    head_dec.pred_taken = head.pred_taken;
    head_dec.inst       = head.inst;
    case (head.inst[6:0])
      OPC_LUI, OPC_AUIPC: begin
        head_dec.unit = UNIT_ALU;
        head_dec.rd   = head.inst[11:7];
        head_dec.imm  = imm_u;
      end
      OPC_JAL: begin
        head_dec.unit = UNIT_BRANCH;
        head_dec.rd   = head.inst[11:7];
        head_dec.imm  = imm_j;
      end
      OPC_JALR: begin
        head_dec.unit   = UNIT_BRANCH;
        head_dec.rd     = head.inst[11:7];
        head_dec.rs1    = head.inst[19:15];
        head_dec.funct3 = head.inst[14:12];
        head_dec.imm    = imm_i;
      end
      OPC_BRANCH: begin
        head_dec.unit   = UNIT_BRANCH;
        head_dec.rs1    = head.inst[19:15];
        head_dec.rs2    = head.inst[24:20];
        head_dec.funct3 = head.inst[14:12];
        head_dec.imm    = imm_b;
      end
      OPC_LOAD: begin
        head_dec.unit   = UNIT_LSQ;
        head_dec.rd     = head.inst[11:7];
        head_dec.rs1    = head.inst[19:15];
        head_dec.funct3 = head.inst[14:12];
        head_dec.imm    = imm_i;
      end
      OPC_STORE: begin
        head_dec.unit   = UNIT_LSQ;
        head_dec.rs1    = head.inst[19:15];
        head_dec.rs2    = head.inst[24:20];
        head_dec.funct3 = head.inst[14:12];
        head_dec.imm    = imm_s;
      end
      OPC_OPIMM: begin
        head_dec.unit   = UNIT_ALU;
        head_dec.rd     = head.inst[11:7];
        head_dec.rs1    = head.inst[19:15];
        head_dec.funct3 = head.inst[14:12];
        // Shifts carry a 5-bit shamt; only SRAI/SRLI distinguish via bit 30.
        if (head.inst[14:12] == 3'b001 || head.inst[14:12] == 3'b101) begin
          head_dec.imm = XLEN'(head.inst[24:20]);
        end else begin
          head_dec.imm = imm_i;
        end
        head_dec.funct7b5 = (head.inst[14:12] == 3'b101) && head.inst[30];
      end
      OPC_OP: begin
        head_dec.unit     = UNIT_ALU;
        head_dec.rd       = head.inst[11:7];
        head_dec.rs1      = head.inst[19:15];
        head_dec.rs2      = head.inst[24:20];
        head_dec.funct3   = head.inst[14:12];
        head_dec.funct7b5 = head.inst[30];
      end
      default: ;
    endcase
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    dec_d       = dec_q;
    if (q.in_flush) begin
      // Decoded data regs keep their contents; only validity is dropped.
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      out_valid_d = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_d    = rd_ptr_q + PTR_ONE;
        dec_d       = head_dec;
        out_valid_d = 1'b1;
      end else if (q.out_ready) begin
        out_valid_d = 1'b0;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      dec_q       <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      dec_q       <= dec_d;
    end
  end

  // Storage array needs no reset: entries are only read behind a nonzero count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{inst: q.in_inst, pc: q.in_pc, pred_taken: q.in_pred_taken};
    end
  end

  assign q.out_valid      = out_valid_q;
  assign q.out_unit       = dec_q.unit;
  assign q.out_funct3     = dec_q.funct3;
  assign q.out_funct7b5   = dec_q.funct7b5;
  assign q.out_rs1        = dec_q.rs1;
  assign q.out_rs2        = dec_q.rs2;
  assign q.out_rd         = dec_q.rd;
  assign q.out_imm        = dec_q.imm;
  assign q.out_pc         = dec_q.pc;
  assign q.out_pred_taken = dec_q.pred_taken;
  assign q.out_inst       = dec_q.inst;
endmodule

// File: tb/tb_decode_queue.sv
// tb/tb_decode_queue.sv - self-checking bench for decode_queue
module tb_decode_queue;
  localparam int DEPTH = 8;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        pt;
  } ent_t;

  typedef struct packed {
    logic [1:0]  unit;
    logic [2:0]  f3;
    logic        f7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [31:0] pc;
    logic        pt;
    logic [31:0] inst;
  } dec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  decode_queue_if #(.XLEN(32)) bus ();
  decode_queue #(.DEPTH(DEPTH), .XLEN(32)) dut (.clk(clk), .rst(rst), .q(bus));

  ent_t        fifo[$];
  dec_t        slot;
  logic        slot_v;
  int          passed = 0;
  int          total  = 0;
  logic [31:0] acc_pc[$];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Reference decode built from the immediate formulas with integer shifts.
  function automatic dec_t ref_decode(input ent_t e);
    dec_t        d;
    logic [31:0] x;
    int          s;
    x = e.inst;
    s = $signed(x);
    d = '0;
    d.pc = e.pc;
    d.pt = e.pt;
    d.inst = x;
    case (x[6:0])
      7'h37, 7'h17: begin d.rd = x[11:7]; d.imm = {x[31:12], 12'h000}; end
      7'h6F: begin
        d.unit = 2'd1; d.rd = x[11:7];
        d.imm = 32'((s >>> 31) << 20) | (32'(x[19:12]) << 12) | (32'(x[20]) << 11) | (32'(x[30:21]) << 1);
      end
      7'h67: begin d.unit = 2'd1; d.rd = x[11:7]; d.rs1 = x[19:15]; d.f3 = x[14:12]; d.imm = 32'(s >>> 20); end
      7'h63: begin
        d.unit = 2'd1; d.rs1 = x[19:15]; d.rs2 = x[24:20]; d.f3 = x[14:12];
        d.imm = 32'((s >>> 31) << 12) | (32'(x[7]) << 11) | (32'(x[30:25]) << 5) | (32'(x[11:8]) << 1);
      end
      7'h03: begin d.unit = 2'd2; d.rd = x[11:7]; d.rs1 = x[19:15]; d.f3 = x[14:12]; d.imm = 32'(s >>> 20); end
      7'h23: begin
        d.unit = 2'd2; d.rs1 = x[19:15]; d.rs2 = x[24:20]; d.f3 = x[14:12];
        d.imm = 32'((s >>> 25) << 5) | 32'(x[11:7]);
      end
      7'h13: begin
        d.rd = x[11:7]; d.rs1 = x[19:15]; d.f3 = x[14:12];
        d.imm = (x[14:12] == 3'd1 || x[14:12] == 3'd5) ? 32'(x[24:20]) : 32'(s >>> 20);
        d.f7 = (x[14:12] == 3'd5) ? x[30] : 1'b0;
      end
      7'h33: begin d.rd = x[11:7]; d.rs1 = x[19:15]; d.rs2 = x[24:20]; d.f3 = x[14:12]; d.f7 = x[30]; end
      default: d.unit = 2'd3;
    endcase
    return d;
  endfunction

  function automatic dec_t dut_view();
    dec_t d;
    d.unit = bus.out_unit;  d.f3 = bus.out_funct3; d.f7 = bus.out_funct7b5;
    d.rs1 = bus.out_rs1;    d.rs2 = bus.out_rs2;   d.rd = bus.out_rd;
    d.imm = bus.out_imm;    d.pc = bus.out_pc;     d.pt = bus.out_pred_taken;
    d.inst = bus.out_inst;
    return d;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] x;
    x = $urandom;
    case ($urandom_range(0, 9))
      0: x[6:0] = 7'h37;
      1: x[6:0] = 7'h17;
      2: x[6:0] = 7'h6F;
      3: x[6:0] = 7'h67;
      4: x[6:0] = 7'h63;
      5: x[6:0] = 7'h03;
      6: x[6:0] = 7'h23;
      7: x[6:0] = 7'h13;
      8: x[6:0] = 7'h33;
      default: x[6:0] = 7'($urandom);
    endcase
    return x;
  endfunction

  // Advance the reference by one clock using the inputs about to be sampled.
  task automatic model_step();
    logic do_push, do_pop;
    if (rst) begin
      fifo.delete();
      slot_v = 1'b0;
      slot = '0;
    end else if (bus.in_flush) begin
      fifo.delete();
      slot_v = 1'b0;
    end else begin
      do_push = bus.in_valid && (fifo.size() < DEPTH);
      do_pop  = (fifo.size() != 0) && (!slot_v || bus.out_ready);
      if (do_pop) begin
        slot = ref_decode(fifo[0]);
        void'(fifo.pop_front());
        slot_v = 1'b1;
      end else if (bus.out_ready) begin
        slot_v = 1'b0;
      end
      if (do_push) fifo.push_back('{inst: bus.in_inst, pc: bus.in_pc, pt: bus.in_pred_taken});
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("in_ready", bus.in_ready, fifo.size() < DEPTH);
    check("out_valid", bus.out_valid, slot_v);
    check("decoded", dut_view(), slot);
  endtask

  task automatic idle();
    bus.in_valid = 1'b0; bus.in_inst = '0; bus.in_pc = '0;
    bus.in_pred_taken = 1'b0; bus.in_flush = 1'b0; bus.out_ready = 1'b0;
  endtask

  task automatic send(input logic [31:0] inst, input logic [31:0] pc, input logic pt);
    bus.in_valid = 1'b1; bus.in_inst = inst; bus.in_pc = pc; bus.in_pred_taken = pt;
    bus.out_ready = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    check("lat_accept_plus1", bus.out_valid, 1'b0);
    tick();
    check("lat_accept_plus2", bus.out_valid, 1'b1);
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("consumed", bus.out_valid, 1'b0);
  endtask

  initial begin
    slot = '0;
    slot_v = 1'b0;
    idle();
    rst = 1'b1;
    tick();
    tick();
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_imm", bus.out_imm, 32'h0);
    check("rst_out_inst", bus.out_inst, 32'h0);
    rst = 1'b0;
    tick();
    check("rst_in_ready", bus.in_ready, 1'b1);

    send(32'h00500093, 32'h40, 1'b0);
    check("addi_unit", bus.out_unit, 2'd0);
    check("addi_rd", bus.out_rd, 5'd1);
    check("addi_rs1", bus.out_rs1, 5'd0);
    check("addi_rs2", bus.out_rs2, 5'd0);
    check("addi_imm", bus.out_imm, 32'd5);
    check("addi_funct3", bus.out_funct3, 3'd0);
    consume();

    send(32'h0020A423, 32'h44, 1'b0);
    check("sw_unit", bus.out_unit, 2'd2);
    check("sw_rs1", bus.out_rs1, 5'd1);
    check("sw_rs2", bus.out_rs2, 5'd2);
    check("sw_rd", bus.out_rd, 5'd0);
    check("sw_imm", bus.out_imm, 32'd8);
    check("sw_funct3", bus.out_funct3, 3'b010);
    consume();

    send(32'hFE208EE3, 32'h100, 1'b1);
    check("beq_unit", bus.out_unit, 2'd1);
    check("beq_rs1", bus.out_rs1, 5'd1);
    check("beq_rs2", bus.out_rs2, 5'd2);
    check("beq_rd", bus.out_rd, 5'd0);
    check("beq_imm", bus.out_imm, 32'hFFFFFFFC);
    check("beq_pc", bus.out_pc, 32'h100);
    check("beq_pred", bus.out_pred_taken, 1'b1);
    consume();

    send(32'h4041D193, 32'h104, 1'b0);
    check("srai_unit", bus.out_unit, 2'd0);
    check("srai_f7b5", bus.out_funct7b5, 1'b1);
    check("srai_imm", bus.out_imm, 32'd4);
    check("srai_rd", bus.out_rd, 5'd3);
    check("srai_rs1", bus.out_rs1, 5'd3);
    consume();

    send(32'h0000007F, 32'h108, 1'b0);
    check("ill_unit", bus.out_unit, 2'd3);
    check("ill_rs1", bus.out_rs1, 5'd0);
    check("ill_rs2", bus.out_rs2, 5'd0);
    check("ill_rd", bus.out_rd, 5'd0);
    check("ill_imm", bus.out_imm, 32'd0);
    check("ill_funct3", bus.out_funct3, 3'd0);
    check("ill_inst", bus.out_inst, 32'h0000007F);
    check("ill_pc", bus.out_pc, 32'h108);
    consume();

    bus.out_ready = 1'b0;
    for (int i = 0; i < 12; i++) begin
      bus.in_valid = 1'b1;
      bus.in_inst = rand_inst();
      bus.in_pc = 32'h1000 + 32'(4 * i);
      if (bus.in_ready) acc_pc.push_back(bus.in_pc);
      tick();
    end
    bus.in_valid = 1'b0;
    check("fill_accepted", acc_pc.size(), 9);
    check("fill_in_ready", bus.in_ready, 1'b0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      check("drain_valid", bus.out_valid, 1'b1);
      check("drain_pc", bus.out_pc, acc_pc[i]);
      tick();
    end
    check("drain_empty", bus.out_valid, 1'b0);

    bus.out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = 1'b1;
      bus.in_inst = rand_inst();
      bus.in_pc = 32'h2000 + 32'(4 * i);
      tick();
    end
    bus.in_flush = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_pc = 32'hDEADBEE0;
    bus.out_ready = 1'b1;
    tick();
    check("flush_out_valid", bus.out_valid, 1'b0);
    check("flush_in_ready", bus.in_ready, 1'b1);
    bus.in_flush = 1'b0;
    bus.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("flush_dropped", bus.out_valid, 1'b0);
    end

    for (int c = 0; c < 800; c++) begin
      bus.in_valid = $urandom_range(0, 9) < 7;
      bus.in_inst = rand_inst();
      bus.in_pc = $urandom & 32'hFFFFFFFC;
      bus.in_pred_taken = 1'($urandom);
      bus.in_flush = $urandom_range(0, 39) == 0;
      bus.out_ready = ((c / 100) % 2 == 0) ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 3);
      rst = (c == 400);
      tick();
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
